// File: rtl/mcp3221_poll_scheduler_if.sv
// Request/response bus between the poll scheduler (master) and the shared MCP3221 I2C core
// (slave), plus the core's recovery reset.
interface mcp3221_poll_scheduler_if;
  logic [6:0]  core_din_device_address;
  logic        core_din_valid;
  logic        core_din_ready;
  logic [15:0] core_dout_register_data;
  logic [2:0]  core_dout_acks_received;
  logic        core_dout_valid;
  logic        core_dout_ready;
  logic        core_reset;

  modport master (
    output core_din_device_address,
    output core_din_valid,
    input  core_din_ready,
    input  core_dout_register_data,
    input  core_dout_acks_received,
    input  core_dout_valid,
    output core_dout_ready,
    output core_reset
  );

  modport slave (
    input  core_din_device_address,
    input  core_din_valid,
    output core_din_ready,
    output core_dout_register_data,
    output core_dout_acks_received,
    output core_dout_valid,
    input  core_dout_ready,
    input  core_reset
  );
endinterface

// File: rtl/mcp3221_poll_scheduler.sv
// Periodic round-robin poller for up to eight MCP3221 ADCs sharing one I2C core.
// Each period tick starts a round over the latched device mask; every slot gets one
// transaction, a validated 12-bit sample strobe, and a hung core is recovered by a reset pulse.
module mcp3221_poll_scheduler #(
  parameter int unsigned G_NUM_DEVICES    = 4,
  parameter int unsigned G_PERIOD_CYCLES  = 100000,
  parameter int unsigned G_TIMEOUT_CYCLES = 50000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cfg_enable,
  input  logic [G_NUM_DEVICES-1:0]   cfg_device_mask,
  input  logic [7*G_NUM_DEVICES-1:0] cfg_device_addresses,
  mcp3221_poll_scheduler_if.master   core,
  output logic [11:0]                sample_data,
  output logic [2:0]                 sample_index,
  output logic                       sample_error,
  output logic                       sample_valid,
  output logic                       overrun_sticky,
  output logic [15:0]                error_count
);

  localparam int unsigned PerW = (G_PERIOD_CYCLES > 1) ? $clog2(G_PERIOD_CYCLES) : 1;
  localparam int unsigned TmoW = $clog2(G_TIMEOUT_CYCLES + 1);

  // Core reset is held for RecRstLast+1 cycles, then the core gets RecEnd-RecRstLast quiet
  // cycles before the error sample is published and the next slot is issued.
  localparam logic [2:0] RecRstLast = 3'd3;
  localparam logic [2:0] RecEnd     = 3'd5;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWait,
    StPublish,
    StRecover
  } state_e;

  state_e                   state_q, state_d;
  logic [PerW-1:0]          period_q, period_d;
  logic [G_NUM_DEVICES-1:0] mask_q, mask_d;
  logic [2:0]               slot_q, slot_d;
  logic [TmoW-1:0]          timer_q, timer_d;
  logic [2:0]               rec_cnt_q, rec_cnt_d;
  logic [6:0]               din_addr_q, din_addr_d;
  logic                     din_valid_q, din_valid_d;
  logic                     dout_ready_q, dout_ready_d;
  logic                     core_reset_q, core_reset_d;
  logic [11:0]              sample_data_q, sample_data_d;
  logic [2:0]               sample_index_q, sample_index_d;
  logic                     sample_error_q, sample_error_d;
  logic                     sample_valid_q, sample_valid_d;
  logic                     overrun_q, overrun_d;
  logic [15:0]              error_count_q, error_count_d;

  logic        tick;
  logic [3:0]  first_hit;
  logic [3:0]  next_hit;
  logic [6:0]  first_addr;
  logic [6:0]  next_addr;
  logic        pub_go;
  logic        pub_err;
  logic [11:0] pub_value;
  logic        unused_acks;

  // Returns {found, index} of the lowest set bit of m at or above position from.
  function automatic logic [3:0] find_slot(input logic [G_NUM_DEVICES-1:0] m, input int from);
    logic [3:0] r;
    r = '0;
    for (int i = int'(G_NUM_DEVICES) - 1; i >= 0; i--) begin
      if (m[i] && (i >= from)) begin
        r = {1'b1, i[2:0]};
      end
    end
    return r;
  endfunction

  assign tick       = cfg_enable && (period_q == PerW'(G_PERIOD_CYCLES - 1));
  assign first_hit  = find_slot(cfg_device_mask, 0);
  assign next_hit   = find_slot(mask_q, int'(slot_q) + 1);
  assign first_addr = cfg_device_addresses[7*int'(first_hit[2:0]) +: 7];
  assign next_addr  = cfg_device_addresses[7*int'(next_hit[2:0]) +: 7];

  // Only the address-ack flag decides validity; the data-byte acks are informational.
  assign unused_acks = ^core.core_dout_acks_received[2:1];

  // Next-state and next-output logic for the period counter and the polling FSM.
  always_comb begin
    state_d        = state_q;
    mask_d         = mask_q;
    slot_d         = slot_q;
    timer_d        = timer_q;
    rec_cnt_d      = rec_cnt_q;
    din_addr_d     = din_addr_q;
    din_valid_d    = din_valid_q;
    dout_ready_d   = dout_ready_q;
    core_reset_d   = core_reset_q;
    sample_data_d  = sample_data_q;
    sample_index_d = sample_index_q;
    sample_error_d = sample_error_q;
    sample_valid_d = 1'b0;
    error_count_d  = error_count_q;
    pub_go         = 1'b0;
    pub_err        = 1'b0;
    pub_value      = '0;

    // Counter is parked at zero while disabled so the first round starts a full period later.
    if (!cfg_enable || (period_q == PerW'(G_PERIOD_CYCLES - 1))) begin
      period_d = '0;
    end else begin
      period_d = period_q + 1'b1;
    end

    // A tick that finds a round in progress is dropped and only remembered here.
    overrun_d = overrun_q | (tick && (state_q != StIdle));

    unique case (state_q)
      StIdle: begin
        if (tick && (|cfg_device_mask)) begin
          mask_d      = cfg_device_mask;
          slot_d      = first_hit[2:0];
          din_addr_d  = first_addr;
          din_valid_d = 1'b1;
          state_d     = StIssue;
        end
      end
      StIssue: begin
        if (din_valid_q && core.core_din_ready) begin
          din_valid_d  = 1'b0;
          dout_ready_d = 1'b1;
          timer_d      = '0;
          state_d      = StWait;
        end
      end
      StWait: begin
        if (core.core_dout_valid) begin
          dout_ready_d = 1'b0;
          pub_go       = 1'b1;
          pub_err      = !core.core_dout_acks_received[0] ||
                         (core.core_dout_register_data[15:12] != 4'h0);
          pub_value    = core.core_dout_register_data[11:0];
        end else if (timer_q == TmoW'(G_TIMEOUT_CYCLES - 1)) begin
          dout_ready_d = 1'b0;
          core_reset_d = 1'b1;
          rec_cnt_d    = '0;
          state_d      = StRecover;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StPublish: begin
        if (cfg_enable && next_hit[3]) begin
          slot_d      = next_hit[2:0];
          din_addr_d  = next_addr;
          din_valid_d = 1'b1;
          state_d     = StIssue;
        end else begin
          state_d = StIdle;
        end
      end
      StRecover: begin
        rec_cnt_d = rec_cnt_q + 1'b1;
        if (rec_cnt_q == RecRstLast) begin
          core_reset_d = 1'b0;
        end
        if (rec_cnt_q == RecEnd) begin
          pub_go  = 1'b1;
          pub_err = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Shared publish path for both a normal completion and a timeout.
    if (pub_go) begin
      state_d        = StPublish;
      sample_valid_d = 1'b1;
      sample_index_d = slot_q;
      sample_error_d = pub_err;
      sample_data_d  = pub_err ? 12'h000 : pub_value;
      if (pub_err && (error_count_q != 16'hFFFF)) begin
        error_count_d = error_count_q + 1'b1;
      end
    end
  end

  // State and registered outputs; reset abandons any transaction in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= StIdle;
      period_q       <= '0;
      mask_q         <= '0;
      slot_q         <= '0;
      timer_q        <= '0;
      rec_cnt_q      <= '0;
      din_addr_q     <= '0;
      din_valid_q    <= 1'b0;
      dout_ready_q   <= 1'b0;
      core_reset_q   <= 1'b0;
      sample_data_q  <= '0;
      sample_index_q <= '0;
      sample_error_q <= 1'b0;
      sample_valid_q <= 1'b0;
      overrun_q      <= 1'b0;
      error_count_q  <= '0;
    end else begin
      state_q        <= state_d;
      period_q       <= period_d;
      mask_q         <= mask_d;
      slot_q         <= slot_d;
      timer_q        <= timer_d;
      rec_cnt_q      <= rec_cnt_d;
      din_addr_q     <= din_addr_d;
      din_valid_q    <= din_valid_d;
      dout_ready_q   <= dout_ready_d;
      core_reset_q   <= core_reset_d;
      sample_data_q  <= sample_data_d;
      sample_index_q <= sample_index_d;
      sample_error_q <= sample_error_d;
      sample_valid_q <= sample_valid_d;
      overrun_q      <= overrun_d;
      error_count_q  <= error_count_d;
    end
  end

  assign core.core_din_device_address = din_addr_q;
  assign core.core_din_valid          = din_valid_q;
  assign core.core_dout_ready         = dout_ready_q;
  assign core.core_reset              = core_reset_q;

  assign sample_data    = sample_data_q;
  assign sample_index   = sample_index_q;
  assign sample_error   = sample_error_q;
  assign sample_valid   = sample_valid_q;
  assign overrun_sticky = overrun_q;
  assign error_count    = error_count_q;

endmodule

// File: tb/tb_mcp3221_poll_scheduler.sv
// Bench for mcp3221_poll_scheduler: behavioural I2C-core model, table vectors, directed corner
// sequences and randomized rounds checked against a per-round expected-strobe model.
module tb_mcp3221_poll_scheduler;
  localparam int unsigned N   = 4;
  localparam int unsigned PER = 100;
  localparam int unsigned TMO = 30;

  logic          clk = 1'b0;
  logic          reset;
  logic          cfg_enable;
  logic [N-1:0]  cfg_mask;
  logic [7*N-1:0] cfg_addr;
  logic [11:0]   sample_data;
  logic [2:0]    sample_index;
  logic          sample_error;
  logic          sample_valid;
  logic          overrun_sticky;
  logic [15:0]   error_count;

  mcp3221_poll_scheduler_if core_if();

  mcp3221_poll_scheduler #(
    .G_NUM_DEVICES   (N),
    .G_PERIOD_CYCLES (PER),
    .G_TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .cfg_enable          (cfg_enable),
    .cfg_device_mask     (cfg_mask),
    .cfg_device_addresses(cfg_addr),
    .core                (core_if.master),
    .sample_data         (sample_data),
    .sample_index        (sample_index),
    .sample_error        (sample_error),
    .sample_valid        (sample_valid),
    .overrun_sticky      (overrun_sticky),
    .error_count         (error_count)
  );

  always #5 clk = ~clk;

  logic [6:0] addr_tab [N] = '{7'h4D, 7'h4E, 7'h48, 7'h4A};
  assign cfg_addr = {addr_tab[3], addr_tab[2], addr_tab[1], addr_tab[0]};

  // Per-slot behaviour of the modelled I2C core.
  logic [15:0] b_data [N];
  logic [2:0]  b_acks [N];
  bit          b_hang [N];
  int          b_rdy  [N];
  int          b_rsp  [N];

  typedef struct {
    int          idx;
    logic        err;
    logic [11:0] data;
    logic [15:0] ec;
  } exp_t;

  exp_t       exp_q[$];
  logic [6:0] iss_q[$];
  int         issued_cnt = 0;
  int         exp_ec = 0;
  bit         stable_bad = 0;
  int         cyc = 0;
  int         last_pulse = 0;
  int         pulses = 0;
  int         fall_cyc = 0;
  int         dv_rise_cyc = 0;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
    end
  endtask

  function automatic int slot_of(input logic [6:0] a);
    int r;
    r = 0;
    for (int i = 0; i < int'(N); i++) if (addr_tab[i] == a) r = i;
    return r;
  endfunction

  // Reference model: one strobe per set mask bit, ascending, with the validity rules applied.
  task automatic push_round(input logic [N-1:0] m);
    exp_t e;
    for (int i = 0; i < int'(N); i++) begin
      if (m[i]) begin
        e.idx  = i;
        e.err  = b_hang[i] || !b_acks[i][0] || (b_data[i][15:12] != 4'h0);
        e.data = e.err ? 12'h000 : b_data[i][11:0];
        if (e.err && exp_ec != 16'hFFFF) exp_ec++;
        e.ec   = 16'(exp_ec);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic set_all(input logic [15:0] d, input logic [2:0] a, input int rdy, input int rsp);
    for (int i = 0; i < int'(N); i++) begin
      b_data[i] = d; b_acks[i] = a; b_hang[i] = 0; b_rdy[i] = rdy; b_rsp[i] = rsp;
    end
  endtask

  // Enable, wait for the round's expected strobes to drain, then disable.
  task automatic run_round(input logic [N-1:0] m, input string name);
    bit done;
    cfg_mask   = m;
    cfg_enable = 1'b1;
    done = 0;
    for (int c = 0; c < 1000 && !done; c++) begin
      @(negedge clk);
      #1;
      if (exp_q.size() == 0) done = 1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s_round_timeout: got %0d strobes outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
    cfg_enable = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // Strobe monitor: compares every published sample against the reference queue.
  initial begin : strobe_mon
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && sample_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_strobe: got idx %0d data 0x%0h, required no strobe",
                   sample_index, sample_data);
        end else begin
          e = exp_q.pop_front();
          check("strobe_idx", 32'(sample_index), 32'(e.idx));
          check("strobe_err", 32'(sample_error), 32'(e.err));
          check("strobe_data", 32'(sample_data), 32'(e.data));
          check("error_count", 32'(error_count), 32'(e.ec));
          if (iss_q.size() == 0) begin
            errors++;
            $display("FAIL issued_addr: got no issued request, required addr 0x%0h",
                     addr_tab[e.idx]);
          end else begin
            check("issued_addr", 32'(iss_q.pop_front()), 32'(addr_tab[e.idx]));
          end
        end
      end
    end
  end

  // Behavioural I2C core: accepts after b_rdy cycles, answers after b_rsp cycles or hangs.
  initial begin : core_model
    int ph;
    int cnt;
    int cur;
    logic [6:0] lat;
    ph = 0; cnt = 0; cur = 0; lat = '0;
    core_if.core_din_ready          = 1'b0;
    core_if.core_dout_valid         = 1'b0;
    core_if.core_dout_register_data = '0;
    core_if.core_dout_acks_received = '0;
    forever begin
      @(negedge clk);
      if (reset || core_if.core_reset) begin
        core_if.core_din_ready  = 1'b0;
        core_if.core_dout_valid = 1'b0;
        ph = 0;
      end else begin
        case (ph)
          0: begin
            core_if.core_din_ready  = 1'b0;
            core_if.core_dout_valid = 1'b0;
            if (core_if.core_din_valid) begin
              lat = core_if.core_din_device_address;
              cur = slot_of(lat);
              cnt = b_rdy[cur];
              ph  = 1;
            end
          end
          2: begin
            core_if.core_din_ready = 1'b0;
            if (!b_hang[cur]) begin
              if (cnt == 0) begin
                core_if.core_dout_valid         = 1'b1;
                core_if.core_dout_register_data = b_data[cur];
                core_if.core_dout_acks_received = b_acks[cur];
                ph = 3;
              end else begin
                cnt--;
              end
            end
          end
          3: begin
            core_if.core_dout_valid = 1'b0;
            ph = 0;
          end
          default: ;
        endcase
        if (ph == 1) begin
          if (!core_if.core_din_valid || core_if.core_din_device_address != lat) stable_bad = 1;
          if (cnt == 0) begin
            core_if.core_din_ready = 1'b1;
            iss_q.push_back(lat);
            issued_cnt++;
            cnt = b_rsp[cur];
            ph  = 2;
          end else begin
            cnt--;
          end
        end
      end
    end
  end

  // Tracks core_reset pulse widths and din_valid rise times.
  initial begin : pulse_mon
    int  run;
    bit  prev_dv;
    run = 0; prev_dv = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (core_if.core_reset) begin
        run++;
      end else if (run != 0) begin
        last_pulse = run;
        pulses++;
        fall_cyc = cyc;
        run = 0;
      end
      if (core_if.core_din_valid && !prev_dv) dv_rise_cyc = cyc;
      prev_dv = core_if.core_din_valid;
    end
  end

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [N-1:0] mask;
    logic [15:0]  data;
    logic [2:0]   acks;
    logic         exp_err;
    logic [11:0]  exp_data;
  } vec_t;

  initial begin : main
    vec_t vecs[6];
    exp_t e;
    int   start;
    int   p0;
    bit   seen;
    bit   done;

    vecs[0] = '{4'b0101, 16'h0ABC, 3'b111, 1'b0, 12'hABC};
    vecs[1] = '{4'b1111, 16'h0FFF, 3'b001, 1'b0, 12'hFFF};
    vecs[2] = '{4'b0001, 16'h1000, 3'b111, 1'b1, 12'h000};
    vecs[3] = '{4'b1000, 16'h0123, 3'b110, 1'b1, 12'h000};
    vecs[4] = '{4'b0110, 16'h0000, 3'b111, 1'b0, 12'h000};
    vecs[5] = '{4'b1010, 16'hF555, 3'b111, 1'b1, 12'h000};

    reset = 1'b1; cfg_enable = 1'b0; cfg_mask = '0;
    set_all(16'h0000, 3'b111, 0, 1);
    repeat (3) @(negedge clk);
    check("rst_din_valid", 32'(core_if.core_din_valid), 0);
    check("rst_dout_ready", 32'(core_if.core_dout_ready), 0);
    check("rst_core_reset", 32'(core_if.core_reset), 0);
    check("rst_sample_valid", 32'(sample_valid), 0);
    check("rst_error_count", 32'(error_count), 0);
    check("rst_overrun", 32'(overrun_sticky), 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Address nack on slot 1 only: error strobe, round continues.
    set_all(16'h0123, 3'b111, 0, 1);
    b_acks[1] = 3'b000;
    push_round(4'b0111);
    run_round(4'b0111, "nack");
    check("nack_error_count", 32'(error_count), 1);

    // Table vectors: same core answer for every slot in the mask.
    for (int v = 0; v < 6; v++) begin
      set_all(vecs[v].data, vecs[v].acks, v % 3, (v * 2) % 5);
      for (int i = 0; i < int'(N); i++) begin
        if (vecs[v].mask[i]) begin
          e.idx  = i;
          e.err  = vecs[v].exp_err;
          e.data = vecs[v].exp_data;
          if (vecs[v].exp_err) exp_ec++;
          e.ec   = 16'(exp_ec);
          exp_q.push_back(e);
        end
      end
      run_round(vecs[v].mask, "table");
    end
    check("table_error_count", 32'(error_count), 32'(exp_ec));

    // Core holds din_ready low 20 cycles: request held stable, issued once.
    set_all(16'h0456, 3'b111, 0, 1);
    b_rdy[0] = 20;
    stable_bad = 0;
    start = issued_cnt;
    push_round(4'b0001);
    run_round(4'b0001, "stall");
    check("stall_stable", 32'(stable_bad), 0);
    check("stall_single_issue", 32'(issued_cnt - start), 1);

    // Slot 0 hangs: 4-cycle core reset, error strobe, then slot 1 is served.
    set_all(16'h0777, 3'b111, 0, 2);
    b_hang[0] = 1;
    p0 = pulses;
    push_round(4'b0011);
    run_round(4'b0011, "hang");
    check("hang_pulse_count", 32'(pulses - p0), 1);
    check("hang_pulse_width", 32'(last_pulse), 4);
    check("hang_release_gap_ok", 32'(dv_rise_cyc - fall_cyc >= 2), 1);

    // Randomized rounds against the reference model.
    for (int r = 0; r < 25; r++) begin
      for (int i = 0; i < int'(N); i++) begin
        b_data[i] = {($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom), 12'($urandom)};
        b_acks[i] = {2'($urandom), ($urandom_range(0, 3) != 0)};
        b_hang[i] = 0;
        b_rdy[i]  = $urandom_range(0, 4);
        b_rsp[i]  = $urandom_range(0, 4);
      end
      cfg_mask = 4'($urandom_range(1, 15));
      push_round(cfg_mask);
      run_round(cfg_mask, "random");
    end
    check("random_error_count", 32'(error_count), 32'(exp_ec));
    check("no_overrun_yet", 32'(overrun_sticky), 0);

    // Round longer than the period: overrun flagged, round not restarted.
    set_all(16'h0321, 3'b111, 0, 1);
    b_hang[0] = 1; b_hang[1] = 1; b_hang[2] = 1;
    start = issued_cnt;
    push_round(4'b1111);
    run_round(4'b1111, "overrun");
    check("overrun_sticky", 32'(overrun_sticky), 1);
    check("overrun_issue_count", 32'(issued_cnt - start), 4);
    repeat (150) @(negedge clk);
    check("overrun_no_restart", 32'(issued_cnt - start), 4);

    // Reset asserted mid-wait: outputs clear at once, nothing until the next tick.
    set_all(16'h0654, 3'b111, 0, 20);
    cfg_mask = 4'b0001;
    cfg_enable = 1'b1;
    done = 0;
    for (int c = 0; c < 300 && !done; c++) begin
      @(negedge clk);
      if (core_if.core_dout_ready) done = 1;
    end
    check("reach_wait", 32'(done), 1);
    #2;
    reset = 1'b1;
    exp_q.delete();
    iss_q.delete();
    exp_ec = 0;
    #1;
    check("midrst_dout_ready", 32'(core_if.core_dout_ready), 0);
    check("midrst_din_valid", 32'(core_if.core_din_valid), 0);
    check("midrst_sample_valid", 32'(sample_valid), 0);
    check("midrst_sample_data", 32'(sample_data), 0);
    check("midrst_overrun", 32'(overrun_sticky), 0);
    check("midrst_error_count", 32'(error_count), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    seen = 0;
    repeat (80) begin
      @(negedge clk);
      if (sample_valid || core_if.core_din_valid) seen = 1;
    end
    check("postrst_quiet", 32'(seen), 0);
    push_round(4'b0001);
    run_round(4'b0001, "postrst");

    // Tick with an empty mask starts nothing.
    start = issued_cnt;
    cfg_mask = '0;
    cfg_enable = 1'b1;
    seen = 0;
    repeat (250) begin
      @(negedge clk);
      if (core_if.core_din_valid) seen = 1;
    end
    cfg_enable = 1'b0;
    check("mask0_no_request", 32'(seen), 0);
    check("mask0_no_issue", 32'(issued_cnt - start), 0);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
